cam_capture: RTL

- Upstream stage of the camera-to-VGA path. Drives the OV7670 `xclk` and samples its pixel bus (`pclk`, `href`, `vref`, `digital`) in the `clk` domain.
- Pairs RGB565 bytes, converts each pixel to 8-bit grayscale and decimates the 640x480 frame to an OUT_W x OUT_H grid.
- Writes each retained pixel through a one-cycle write port into the small frame memory that the VGA video generator reads.

---
 rtl/cam_capture.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/cam_capture.sv
// OV7670 capture front end: drives xclk, pairs RGB565 bytes, converts to grayscale,
// decimates the frame and writes retained pixels into the VGA frame memory.
module cam_capture #(
  parameter int unsigned XCLK_DIV = 4,
  parameter int unsigned IMG_W    = 640,
  parameter int unsigned IMG_H    = 480,
  parameter int unsigned OUT_W    = 16,
  parameter int unsigned OUT_H    = 16,
  parameter int unsigned XDIV     = 40,
  parameter int unsigned YDIV     = 30
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               enable,
  input  logic                               pclk,
  input  logic                               href,
  input  logic                               vref,
  input  logic [7:0]                         digital,
  output logic                               xclk,
  output logic                               we,
  output logic [$clog2(OUT_W*OUT_H)-1:0]     waddr,
  output logic [7:0]                         wdata,
  output logic                               frame_done,
  output logic [7:0]                         frame_count
);

  localparam int unsigned AW   = $clog2(OUT_W*OUT_H);
  localparam int unsigned HALF = XCLK_DIV / 2;
  localparam int unsigned DW   = (HALF > 1) ? $clog2(HALF) : 1;
  localparam int unsigned XW   = (XDIV > 1) ? $clog2(XDIV) : 1;
  localparam int unsigned YW   = (YDIV > 1) ? $clog2(YDIV) : 1;
  localparam int unsigned CW   = $clog2(OUT_W + 1);
  localparam int unsigned RW   = $clog2(OUT_H + 1);

  if (XCLK_DIV < 4 || (XCLK_DIV % 2) != 0) begin : g_bad_xclk_div
    $error("cam_capture: XCLK_DIV must be even and >= 4");
  end
  if (OUT_W*XDIV > IMG_W || OUT_H*YDIV > IMG_H) begin : g_bad_decimation
    $error("cam_capture: decimated grid exceeds source image");
  end

  typedef enum logic [1:0] {WAIT_VS, VBLANK, ACTIVE} state_t;

  state_t          state, state_n;
  logic [DW-1:0]   div_cnt;
  logic [2:0]      pclk_q, href_q, vref_q;
  logic [7:0]      dig_q1, dig_q2;
  logic            byte_ph;
  logic [7:0]      hi_byte;
  logic [XW-1:0]   xph;
  logic [YW-1:0]   yph;
  logic [CW-1:0]   out_col;
  logic [RW-1:0]   out_row;

  logic pe_c, href_fall_c, vref_rise_c, vref_fall_c;
  logic frame_start_c, frame_end_c, pair_en_c, line_end_c, keep_c;
  logic [7:0]    r8_c, g8_c, b8_c;
  logic [9:0]    sum_c;
  logic [AW-1:0] addr_c;

  // xclk divider, free running
  always_ff @(posedge clk) begin
    if (reset) begin
      div_cnt <= '0;
      xclk    <= 1'b0;
    end else if (div_cnt == DW'(HALF - 1)) begin
      div_cnt <= '0;
      xclk    <= ~xclk;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  // Camera bus synchronizers; data delayed to stay aligned with pclk stage 2
  always_ff @(posedge clk) begin
    if (reset) begin
      pclk_q <= '0;
      href_q <= '0;
      vref_q <= '0;
      dig_q1 <= '0;
      dig_q2 <= '0;
    end else begin
      pclk_q <= {pclk_q[1:0], pclk};
      href_q <= {href_q[1:0], href};
      vref_q <= {vref_q[1:0], vref};
      dig_q1 <= digital;
      dig_q2 <= dig_q1;
    end
  end

  assign pe_c        =  pclk_q[1] & ~pclk_q[2];
  assign href_fall_c = ~href_q[1] &  href_q[2];
  assign vref_rise_c =  vref_q[1] & ~vref_q[2];
  assign vref_fall_c = ~vref_q[1] &  vref_q[2];

  always_ff @(posedge clk) begin
    if (reset) state <= WAIT_VS;
    else       state <= state_n;
  end

  always_comb begin
    state_n       = state;
    frame_start_c = 1'b0;
    frame_end_c   = 1'b0;
    unique case (state)
      WAIT_VS: if (vref_rise_c) state_n = VBLANK;
      VBLANK: begin
        if (vref_fall_c && enable) begin
          state_n       = ACTIVE;
          frame_start_c = 1'b1;
        end
      end
      ACTIVE: begin
        if (vref_rise_c) begin
          state_n     = VBLANK;
          frame_end_c = 1'b1;
        end
      end
      default: state_n = WAIT_VS;
    endcase
  end

  // vref rise outranks a coincident pixel edge
  assign pair_en_c  = (state == ACTIVE) && !vref_rise_c && href_q[1] && pe_c;
  assign line_end_c = (state == ACTIVE) && href_fall_c;

  assign r8_c   = {hi_byte[7:3], hi_byte[7:5]};
  assign g8_c   = {hi_byte[2:0], dig_q2[7:5], hi_byte[2:1]};
  assign b8_c   = {dig_q2[4:0], dig_q2[4:2]};
  assign sum_c  = 10'(r8_c) + 10'({g8_c, 1'b0}) + 10'(b8_c);
  assign keep_c = (xph == '0) && (yph == '0) &&
                  (out_col < CW'(OUT_W)) && (out_row < RW'(OUT_H));
  assign addr_c = AW'(32'(out_row) * OUT_W + 32'(out_col));

  // Byte pairing, decimation counters and frame-memory write port
  always_ff @(posedge clk) begin
    if (reset) begin
      byte_ph     <= 1'b0;
      hi_byte     <= '0;
      xph         <= '0;
      yph         <= '0;
      out_col     <= '0;
      out_row     <= '0;
      we          <= 1'b0;
      waddr       <= '0;
      wdata       <= '0;
      frame_done  <= 1'b0;
      frame_count <= '0;
    end else begin
      we         <= 1'b0;
      frame_done <= 1'b0;
      if (frame_start_c) begin
        byte_ph <= 1'b0;
        xph     <= '0;
        yph     <= '0;
        out_col <= '0;
        out_row <= '0;
      end else if (frame_end_c) begin
        frame_done  <= 1'b1;
        frame_count <= frame_count + 8'd1;
      end else if (line_end_c) begin
        byte_ph <= 1'b0;
        xph     <= '0;
        out_col <= '0;
        if (yph == YW'(YDIV - 1)) begin
          yph <= '0;
          if (out_row < RW'(OUT_H)) out_row <= out_row + 1'b1;
        end else begin
          yph <= yph + 1'b1;
        end
      end else if (pair_en_c) begin
        if (!byte_ph) begin
          hi_byte <= dig_q2;
          byte_ph <= 1'b1;
        end else begin
          byte_ph <= 1'b0;
          if (keep_c) begin
            we    <= 1'b1;
            waddr <= addr_c;
            wdata <= sum_c[9:2];
          end
          if (xph == XW'(XDIV - 1)) begin
            xph <= '0;
            if (out_col < CW'(OUT_W)) out_col <= out_col + 1'b1;
          end else begin
            xph <= xph + 1'b1;
          end
        end
      end
    end
  end

endmodule
